hs_assert_monitor: RTL and testbench

Synthesizable protocol checker for a valid/ready handshake. Benches currently check the handshake with simulation-only immediate assertions; this block does the same checking in hardware. It watches one valid/ready/data channel, with no drive of its own, and reports rule violations as one-cycle pulses. It also keeps sticky flags, saturating counters, and a capture of the first failure with its code and cycle timestamp. It sits beside any handshake interface, in the bench or in silicon debug logic.

---
 rtl/hs_assert_monitor.sv | 139 +++++++++++++
 tb/tb_hs_assert_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_assert_monitor.sv
// Hardware checker for a valid/ready handshake. It flags dropped valid, unstable data
// and stall timeouts, and keeps sticky flags, saturating counters and a first-error capture.
module hs_assert_monitor #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             mon_valid,
  input  logic             mon_ready,
  input  logic [DW-1:0]    mon_data,
  output logic             err_drop,
  output logic             err_stable,
  output logic             err_timeout,
  output logic [2:0]       err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] xfer_count,
  output logic [1:0]       first_err_code,
  output logic [TS_W-1:0]  first_err_time
);

  localparam int                WW       = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]     TO_VAL   = WW'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, STALL, TIMED_OUT} state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d, wait_inc;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic [TS_W-1:0]   ts_q;
  logic              drop_q, drop_d;
  logic              stable_q, stable_d;
  logic              timeout_q, timeout_d;
  logic [2:0]        sticky_q;
  logic [CNT_W-1:0]  err_cnt_q, xfer_cnt_q, err_sat;
  logic [CNT_W:0]    err_sum;
  logic [1:0]        err_n, code_q, code_d;
  logic [TS_W-1:0]   time_q;
  logic              active, stalled, stall_now, xfer_now, any_err;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    active    = en && !clr;
    stalled   = (state_q != IDLE);
    stall_now = mon_valid && !mon_ready;
    xfer_now  = active && mon_valid && mon_ready;
    wait_inc  = (wait_q == TO_VAL) ? wait_q : wait_q + 1'b1;

    drop_d    = active && stalled && !mon_valid;
    stable_d  = active && stalled && mon_valid && (mon_data != shadow_q);
    timeout_d = active && (state_q == STALL) && stall_now && (wait_inc == TO_VAL);

    state_d  = state_q;
    wait_d   = wait_q;
    shadow_d = shadow_q;
    if (!active) begin
      state_d = IDLE;
      wait_d  = '0;
    end else if (!stalled) begin
      if (stall_now) begin
        state_d  = STALL;
        wait_d   = WW'(1);
        shadow_d = mon_data;
      end
    end else if (!mon_valid || mon_ready) begin
      state_d = IDLE;
      wait_d  = '0;
    end else begin
      wait_d   = wait_inc;
      shadow_d = mon_data;
      if (timeout_d) state_d = TIMED_OUT;
    end

    err_n   = {1'b0, drop_d} + {1'b0, stable_d} + {1'b0, timeout_d};
    err_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_n);
    err_sat = (err_sum > {1'b0, CNT_MAX}) ? CNT_MAX : err_sum[CNT_W-1:0];
    any_err = drop_d || stable_d || timeout_d;

    // Stable outranks timeout when both fire on one edge; drop never coincides with either.
    code_d = drop_d ? 2'd1 : (stable_d ? 2'd2 : 2'd3);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: the shadow register is reset along with everything else so no stale compare survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      shadow_q   <= '0;
      ts_q       <= '0;
      drop_q     <= 1'b0;
      stable_q   <= 1'b0;
      timeout_q  <= 1'b0;
      sticky_q   <= '0;
      err_cnt_q  <= '0;
      xfer_cnt_q <= '0;
      code_q     <= '0;
      time_q     <= '0;
    end else begin
      ts_q      <= ts_q + 1'b1;
      state_q   <= state_d;
      wait_q    <= wait_d;
      shadow_q  <= shadow_d;
      drop_q    <= drop_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
      if (clr) begin
        sticky_q   <= '0;
        err_cnt_q  <= '0;
        xfer_cnt_q <= '0;
        code_q     <= '0;
        time_q     <= '0;
      end else begin
        sticky_q  <= sticky_q | {timeout_d, stable_d, drop_d};
        err_cnt_q <= err_sat;
        if (xfer_now && (xfer_cnt_q != CNT_MAX)) xfer_cnt_q <= xfer_cnt_q + 1'b1;
        if ((code_q == 2'd0) && any_err) begin
          code_q <= code_d;
          time_q <= ts_q;
        end
      end
    end
  end

  assign err_drop       = drop_q;
  assign err_stable     = stable_q;
  assign err_timeout    = timeout_q;
  assign err_sticky     = sticky_q;
  assign err_count      = err_cnt_q;
  assign xfer_count     = xfer_cnt_q;
  assign first_err_code = code_q;
  assign first_err_time = time_q;

endmodule

// File: tb/tb_hs_assert_monitor.sv
// Bench for hs_assert_monitor: two instances (TIMEOUT=4/CNT_W=2 and TIMEOUT=2/CNT_W=8)
// driven in lockstep and compared every cycle against a stall-length reference model.
module tb_hs_assert_monitor;

  localparam int TO0 = 4, CW0 = 2;
  localparam int TO1 = 2, CW1 = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, v = 1'b0, r = 1'b0;
  logic [7:0] d = 8'h00;

  always #5 clk = ~clk;

  logic           drop0, stab0, tmo0, drop1, stab1, tmo1;
  logic [2:0]     stk0, stk1;
  logic [CW0-1:0] ec0, xc0;
  logic [CW1-1:0] ec1, xc1;
  logic [1:0]     code0, code1;
  logic [15:0]    tm0, tm1;

  hs_assert_monitor #(.DW(8), .TIMEOUT(TO0), .CNT_W(CW0), .TS_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .mon_valid(v), .mon_ready(r), .mon_data(d),
    .err_drop(drop0), .err_stable(stab0), .err_timeout(tmo0), .err_sticky(stk0),
    .err_count(ec0), .xfer_count(xc0), .first_err_code(code0), .first_err_time(tm0));

  hs_assert_monitor #(.DW(8), .TIMEOUT(TO1), .CNT_W(CW1), .TS_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .mon_valid(v), .mon_ready(r), .mon_data(d),
    .err_drop(drop1), .err_stable(stab1), .err_timeout(tmo1), .err_sticky(stk1),
    .err_count(ec1), .xfer_count(xc1), .first_err_code(code1), .first_err_time(tm1));

  typedef struct {
    logic        drop, stable, timeout;
    logic [2:0]  sticky;
    logic [31:0] err, xfer, code, tstamp;
  } res_t;

  res_t       m [2];
  bit         in_stall [2];
  int         slen [2];
  logic [7:0] shadow [2];
  int         ts_m;
  int         n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t get_obs(input int i);
    res_t o;
    if (i == 0) begin
      o.drop = drop0; o.stable = stab0; o.timeout = tmo0; o.sticky = stk0;
      o.err = 32'(ec0); o.xfer = 32'(xc0); o.code = 32'(code0); o.tstamp = 32'(tm0);
    end else begin
      o.drop = drop1; o.stable = stab1; o.timeout = tmo1; o.sticky = stk1;
      o.err = 32'(ec1); o.xfer = 32'(xc1); o.code = 32'(code1); o.tstamp = 32'(tm1);
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i] = '{default: 0};
      in_stall[i] = 0; slen[i] = 0; shadow[i] = 8'h00;
    end
    ts_m = 0;
  endtask

  // Stall length counts without bound; a timeout is the edge where it equals TIMEOUT.
  task automatic model_step(input int i, input bit e, c, vv, rr, input logic [7:0] dd);
    int to, mx;
    bit dr, st, tmo;
    to = (i == 0) ? TO0 : TO1;
    mx = (i == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
    dr = 0; st = 0; tmo = 0;
    if (c) begin
      m[i] = '{default: 0};
      in_stall[i] = 0; slen[i] = 0;
      return;
    end
    if (!e) begin
      in_stall[i] = 0; slen[i] = 0;
    end else begin
      if (in_stall[i]) begin
        if (!vv) begin
          dr = 1; in_stall[i] = 0;
        end else begin
          if (dd != shadow[i]) begin st = 1; shadow[i] = dd; end
          if (rr) in_stall[i] = 0;
          else begin
            slen[i]++;
            if (slen[i] == to) tmo = 1;
          end
        end
      end else if (vv && !rr) begin
        in_stall[i] = 1; slen[i] = 1; shadow[i] = dd;
      end
      if (vv && rr && m[i].xfer < mx) m[i].xfer++;
    end
    m[i].err = (m[i].err + dr + st + tmo > mx) ? mx : m[i].err + dr + st + tmo;
    m[i].sticky = m[i].sticky | {tmo, st, dr};
    if (m[i].code == 0 && (dr || st || tmo)) begin
      m[i].code = dr ? 1 : (st ? 2 : 3);
      m[i].tstamp = ts_m & 32'hFFFF;
    end
    m[i].drop = dr; m[i].stable = st; m[i].timeout = tmo;
  endtask

  task automatic compare_all(input string ph);
    res_t o;
    for (int i = 0; i < 2; i++) begin
      o = get_obs(i);
      check($sformatf("%s d%0d drop", ph, i),    32'(o.drop),    32'(m[i].drop));
      check($sformatf("%s d%0d stable", ph, i),  32'(o.stable),  32'(m[i].stable));
      check($sformatf("%s d%0d timeout", ph, i), 32'(o.timeout), 32'(m[i].timeout));
      check($sformatf("%s d%0d sticky", ph, i),  32'(o.sticky),  32'(m[i].sticky));
      check($sformatf("%s d%0d err_cnt", ph, i), o.err,    m[i].err);
      check($sformatf("%s d%0d xfer", ph, i),    o.xfer,   m[i].xfer);
      check($sformatf("%s d%0d code", ph, i),    o.code,   m[i].code);
      check($sformatf("%s d%0d time", ph, i),    o.tstamp, m[i].tstamp);
    end
  endtask

  task automatic cycle(input string ph, input bit e, c, vv, rr, input logic [7:0] dd);
    en = e; clr = c; v = vv; r = rr; d = dd;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, e, c, vv, rr, dd);
    ts_m++;
    @(negedge clk);
    compare_all(ph);
  endtask

  initial begin
    int t_first, t_now, n_to, to_edge;
    logic [7:0] cur;
    res_t o;

    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // Stall at ts 4 and 5, valid drops at ts 6.
    repeat (4) cycle("idle", 1, 0, 0, 0, 8'h00);
    cycle("drop_s1", 1, 0, 1, 0, 8'h11);
    cycle("drop_s2", 1, 0, 1, 0, 8'h11);
    cycle("drop_v0", 1, 0, 0, 0, 8'h11);
    check("drop pulse", 32'(drop0), 1);
    check("drop code", 32'(code0), 1);
    check("drop time", 32'(tm0), 6);
    check("drop count", 32'(ec0), 1);
    check("drop sticky", 32'(stk0), 1);
    cycle("drop_after", 1, 0, 0, 0, 8'h11);
    check("drop one-cycle", 32'(drop0), 0);

    // Data change while stalled.
    cycle("clr", 1, 1, 0, 0, 8'h00);
    cycle("stb_a5", 1, 0, 1, 0, 8'hA5);
    cycle("stb_5a", 1, 0, 1, 0, 8'h5A);
    check("stable pulse", 32'(stab0), 1);
    check("stable count", 32'(ec0), 1);
    check("stable code", 32'(code0), 2);
    cycle("stb_hold1", 1, 0, 1, 0, 8'h5A);
    check("stable no repeat1", 32'(stab0), 0);
    cycle("stb_hold2", 1, 0, 1, 0, 8'h5A);
    check("stable no repeat2", 32'(stab0), 0);
    cycle("stb_xfer", 1, 0, 1, 1, 8'h5A);

    // Timeout: ten stall edges give exactly one pulse on the 4th.
    cycle("clr", 1, 1, 0, 0, 8'h00);
    n_to = 0; to_edge = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle("to_stall", 1, 0, 1, 0, 8'h33);
      if (tmo0) begin n_to++; to_edge = k; end
    end
    check("timeout pulses", n_to, 1);
    check("timeout edge", to_edge, 4);
    check("timeout count", 32'(ec0), 1);
    check("timeout sticky", 32'(stk0), 4);
    cycle("to_xfer", 1, 0, 1, 1, 8'h33);
    check("timeout xfer", 32'(xc0), 1);
    cycle("to_idle", 1, 0, 0, 0, 8'h33);
    check("timeout idle no drop", 32'(drop0), 0);

    // Timeout and data change together on the TIMEOUT=2 instance.
    cycle("clr", 1, 1, 0, 0, 8'h00);
    cycle("sim_s1", 1, 0, 1, 0, 8'h01);
    cycle("sim_s2", 1, 0, 1, 0, 8'h02);
    check("sim stable", 32'(stab1), 1);
    check("sim timeout", 32'(tmo1), 1);
    check("sim count", 32'(ec1), 2);
    check("sim code", 32'(code1), 2);
    cycle("sim_xfer", 1, 0, 1, 1, 8'h02);

    // Saturation with CNT_W=2, then clr against a violating edge.
    cycle("clr", 1, 1, 0, 0, 8'h00);
    t_first = -1;
    for (int k = 0; k < 5; k++) begin
      cycle("sat_stall", 1, 0, 1, 0, 8'h44);
      if (t_first < 0) t_first = ts_m;
      cycle("sat_drop", 1, 0, 0, 0, 8'h44);
    end
    check("sat count", 32'(ec0), 3);
    check("sat code", 32'(code0), 1);
    check("sat time", 32'(tm0), t_first);
    cycle("clr_stall", 1, 0, 1, 0, 8'h55);
    cycle("clr_viol", 1, 1, 0, 0, 8'h55);
    check("clr drop", 32'(drop0), 0);
    check("clr count", 32'(ec0), 0);
    check("clr sticky", 32'(stk0), 0);
    check("clr code", 32'(code0), 0);
    cycle("ts_stall", 1, 0, 1, 0, 8'h66);
    t_now = ts_m;
    cycle("ts_drop", 1, 0, 0, 0, 8'h66);
    check("ts keeps running", 32'(tm0), t_now);

    // Enable low aborts a stall without reporting it.
    cycle("en_stall", 1, 0, 1, 0, 8'h77);
    cycle("en_off", 0, 0, 0, 0, 8'h77);
    check("en off no drop", 32'(drop0), 0);

    // Randomized traffic.
    cur = 8'h00;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(5) == 0) cur = 8'($urandom);
      cycle("rand", $urandom_range(19) != 0, $urandom_range(49) == 0,
            $urandom_range(3) != 0, $urandom_range(2) == 0, cur);
    end

    // Reset in the middle of a stall.
    cycle("rst_stall0", 1, 0, 1, 0, 8'h88);
    cycle("rst_drop", 1, 0, 0, 0, 8'h88);
    cycle("rst_stall1", 1, 0, 1, 0, 8'h99);
    cycle("rst_stall2", 1, 0, 1, 0, 8'h99);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      o = get_obs(i);
      check($sformatf("async rst d%0d drop", i), 32'(o.drop), 0);
      check($sformatf("async rst d%0d count", i), o.err, 0);
      check($sformatf("async rst d%0d sticky", i), 32'(o.sticky), 0);
      check($sformatf("async rst d%0d xfer", i), o.xfer, 0);
      check($sformatf("async rst d%0d code", i), o.code, 0);
      check($sformatf("async rst d%0d time", i), o.tstamp, 0);
    end
    model_reset();
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1'b1;
    cycle("rst_xfer", 1, 0, 1, 1, 8'h99);
    check("post rst xfer", 32'(xc0), 1);
    check("post rst count", 32'(ec0), 0);
    check("post rst no drop", 32'(drop0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
